// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run-control and debug unit for the CPU core. Produces the core clock enable
// (cpu_en) that every core state element qualifies on. Supports run, halt and
// N-instruction single-step commands, NUM_BP PC breakpoint comparators,
// halt-cause reporting and free-running cycle / retired-instruction counters.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   cmd_run/step/halt   one-cycle command pulses from the debug bus
//   step_n              instruction count, sampled with cmd_step
//   bp_we/idx/addr/     breakpoint slot write port; bp_en_in is the slot
//   bp_en_in            enable written alongside the address
//   pc                  current core PC
//   retire              core completes an instruction this cycle
//   stop                decoder flags a halt instruction at pc
//   cnt_clr             clear both counters
//   cpu_en              core clock enable (combinational)
//   halted              state is HALT
//   halt_cause          0 reset, 1 cmd_halt, 2 step done, 3 breakpoint, 4 stop
//   hit_idx             lowest slot that matched on the last breakpoint halt
//   cycle_cnt           cycles with cpu_en high
//   instret_cnt         instructions retired while enabled
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int XLEN      = 32,
  parameter int NUM_BP    = 4,
  parameter int STEP_W    = 8,
  parameter int CNT_W     = 32,
  parameter int RESET_RUN = 0,
  localparam int BPI_W    = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_halt,
  input  logic [STEP_W-1:0] step_n,
  input  logic              bp_we,
  input  logic [BPI_W-1:0]  bp_idx,
  input  logic [XLEN-1:0]   bp_addr,
  input  logic              bp_en_in,
  input  logic [XLEN-1:0]   pc,
  input  logic              retire,
  input  logic              stop,
  input  logic              cnt_clr,
  output logic              cpu_en,
  output logic              halted,
  output logic [2:0]        halt_cause,
  output logic [BPI_W-1:0]  hit_idx,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instret_cnt
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam logic [2:0] CAUSE_RESET = 3'd0;
  localparam logic [2:0] CAUSE_CMD   = 3'd1;
  localparam logic [2:0] CAUSE_STEP  = 3'd2;
  localparam logic [2:0] CAUSE_BP    = 3'd3;
  localparam logic [2:0] CAUSE_STOP  = 3'd4;

  localparam state_t RESET_STATE = (RESET_RUN != 0) ? S_RUN : S_HALT;

  state_t              state;
  logic [XLEN-1:0]     bp_addr_q [NUM_BP];
  logic [NUM_BP-1:0]   bp_en_q;
  logic [STEP_W-1:0]   remaining;
  logic                skip;       // masks breakpoints until the first retire after resuming

  logic                bp_match;
  logic [BPI_W-1:0]    bp_first;
  logic                bp_hit;
  logic                retired;

  // Lowest enabled slot whose address matches pc. Scanning downward lets the
  // lowest index overwrite any higher match.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    bp_match = 1'b0;
    bp_first = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en_q[i] && (bp_addr_q[i] == pc)) begin
        bp_match = 1'b1;
        bp_first = BPI_W'(i);
      end
    end
  end

  assign bp_hit  = bp_match && !skip;
  // Breakpoints and stop instructions freeze the core before the instruction
  // at pc executes; cmd_halt deliberately does not, so the current one completes.
  assign cpu_en  = (state != S_HALT) && !bp_hit && !stop;
  assign retired = retire && cpu_en;
  assign halted  = (state == S_HALT);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RESET_STATE;
      halt_cause  <= CAUSE_RESET;
      hit_idx     <= '0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      remaining   <= '0;
      skip        <= 1'b0;
      bp_en_q     <= '0;
      // NOTE: the breakpoint table is a small flop array, not a RAM, so it is reset explicitly.
      for (int i = 0; i < NUM_BP; i++) begin
        bp_addr_q[i] <= '0;
      end
    end else begin
      // Breakpoint table write; an index with no matching slot writes nothing.
      for (int i = 0; i < NUM_BP; i++) begin
        if (bp_we && (bp_idx == BPI_W'(i))) begin
          bp_en_q[i]   <= bp_en_in;
          bp_addr_q[i] <= bp_addr;
        end
      end

      // Counters: clear wins over increment.
      if (cnt_clr) begin
        cycle_cnt   <= '0;
        instret_cnt <= '0;
      end else begin
        if (cpu_en)  cycle_cnt   <= cycle_cnt + CNT_W'(1);
        if (retired) instret_cnt <= instret_cnt + CNT_W'(1);
      end

      if (retired) skip <= 1'b0;
      if (retired && (state == S_STEP)) remaining <= remaining - STEP_W'(1);

      case (state)
        S_HALT: begin
          // A zero-length step is a no-op, so it does not shadow cmd_run.
          if (cmd_step && (step_n != '0)) begin
            state     <= S_STEP;
            remaining <= step_n;
            skip      <= 1'b1;
          end else if (cmd_run) begin
            state <= S_RUN;
            skip  <= 1'b1;
          end
        end
        default: begin
          if (cmd_halt) begin
            state      <= S_HALT;
            halt_cause <= CAUSE_CMD;
          end else if (stop) begin
            state      <= S_HALT;
            halt_cause <= CAUSE_STOP;
          end else if (bp_hit) begin
            state      <= S_HALT;
            halt_cause <= CAUSE_BP;
            hit_idx    <= bp_first;
          end else if ((state == S_STEP) && retired && (remaining == STEP_W'(1))) begin
            state      <= S_HALT;
            halt_cause <= CAUSE_STEP;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_ctrl
//
// Self-checking bench for cpu_run_ctrl (NUM_BP=6 so out-of-range slot indices
// are representable, CNT_W=4 so counter wrap is quick to reach). Directed
// scenarios are followed by a randomized phase; every cycle is compared
// against a behavioural model of the run-control rules.
// -----------------------------------------------------------------------------
module tb_cpu_run_ctrl;

  localparam int XLEN     = 32;
  localparam int NUM_BP   = 6;
  localparam int STEP_W   = 8;
  localparam int CNT_W    = 4;
  localparam int BPI_W    = 3;
  localparam int CNT_MASK = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_run, cmd_step, cmd_halt;
  logic [STEP_W-1:0] step_n;
  logic              bp_we;
  logic [BPI_W-1:0]  bp_idx;
  logic [XLEN-1:0]   bp_addr;
  logic              bp_en_in;
  logic [XLEN-1:0]   pc;
  logic              retire, stop, cnt_clr;
  logic              cpu_en, halted;
  logic [2:0]        halt_cause;
  logic [BPI_W-1:0]  hit_idx;
  logic [CNT_W-1:0]  cycle_cnt, instret_cnt;

  cpu_run_ctrl #(
    .XLEN(XLEN), .NUM_BP(NUM_BP), .STEP_W(STEP_W), .CNT_W(CNT_W), .RESET_RUN(0)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt), .step_n(step_n),
    .bp_we(bp_we), .bp_idx(bp_idx), .bp_addr(bp_addr), .bp_en_in(bp_en_in),
    .pc(pc), .retire(retire), .stop(stop), .cnt_clr(cnt_clr),
    .cpu_en(cpu_en), .halted(halted), .halt_cause(halt_cause), .hit_idx(hit_idx),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the run-control rules.
  bit          m_halted, m_stepping, m_skip;
  int          m_cause, m_hit, m_cyc, m_inst, m_rem;
  bit          m_bp_en   [NUM_BP];
  logic [31:0] m_bp_addr [NUM_BP];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_halted   = 1'b1;
    m_stepping = 1'b0;
    m_skip     = 1'b0;
    m_cause    = 0;
    m_hit      = 0;
    m_cyc      = 0;
    m_inst     = 0;
    m_rem      = 0;
    for (int i = 0; i < NUM_BP; i++) begin
      m_bp_en[i]   = 1'b0;
      m_bp_addr[i] = '0;
    end
  endtask

  function automatic int lowest_match();
    for (int i = 0; i < NUM_BP; i++)
      if (m_bp_en[i] && (m_bp_addr[i] == pc)) return i;
    return -1;
  endfunction

  function automatic bit model_en();
    bit hit;
    hit = (lowest_match() >= 0) && !m_skip;
    return !m_halted && !hit && !stop;
  endfunction

  task automatic model_update(input bit en);
    int  mi;
    bit  hit, retired;
    if (rst) begin
      model_reset();
      return;
    end
    mi      = lowest_match();
    hit     = (mi >= 0) && !m_skip;
    retired = retire && en;
    if (bp_we && (int'(bp_idx) < NUM_BP)) begin
      m_bp_en[bp_idx]   = bp_en_in;
      m_bp_addr[bp_idx] = bp_addr;
    end
    if (cnt_clr) begin
      m_cyc  = 0;
      m_inst = 0;
    end else begin
      if (en)      m_cyc  = (m_cyc + 1) & CNT_MASK;
      if (retired) m_inst = (m_inst + 1) & CNT_MASK;
    end
    if (m_halted) begin
      if (cmd_step && (step_n != 0)) begin
        m_halted = 1'b0; m_stepping = 1'b1; m_rem = int'(step_n); m_skip = 1'b1;
      end else if (cmd_run) begin
        m_halted = 1'b0; m_stepping = 1'b0; m_skip = 1'b1;
      end
    end else begin
      if (retired) begin
        m_skip = 1'b0;
        if (m_stepping) m_rem = m_rem - 1;
      end
      if (cmd_halt) begin
        m_halted = 1'b1; m_cause = 1;
      end else if (stop) begin
        m_halted = 1'b1; m_cause = 4;
      end else if (hit) begin
        m_halted = 1'b1; m_cause = 3; m_hit = mi;
      end else if (m_stepping && retired && (m_rem == 0)) begin
        m_halted = 1'b1; m_cause = 2;
      end
    end
  endtask

  // One clock cycle: compare outputs against the model mid-cycle, advance the
  // model with the inputs of this cycle, then return just after the edge.
  task automatic tick();
    bit en;
    @(negedge clk);
    en = model_en();
    check("cpu_en",      32'(cpu_en),      32'(en));
    check("halted",      32'(halted),      32'(m_halted));
    check("halt_cause",  32'(halt_cause),  m_cause);
    check("hit_idx",     32'(hit_idx),     m_hit);
    check("cycle_cnt",   32'(cycle_cnt),   m_cyc);
    check("instret_cnt", 32'(instret_cnt), m_inst);
    model_update(en);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
    bp_we = 1'b0; retire = 1'b0; stop = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic bp_write(input int idx, input logic [31:0] addr, input bit en);
    bp_we = 1'b1; bp_idx = BPI_W'(idx); bp_addr = addr; bp_en_in = en;
    tick();
    bp_we = 1'b0;
  endtask

  task automatic pulse_run();
    cmd_run = 1'b1; tick(); cmd_run = 1'b0;
  endtask

  initial begin
    idle();
    step_n = '0; bp_idx = '0; bp_addr = '0; bp_en_in = 1'b0; pc = '0;

    // Reset: no model comparison while outputs are still unknown.
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    check("rst_halted", 32'(halted), 1);
    check("rst_cpu_en", 32'(cpu_en), 0);
    check("rst_cause",  32'(halt_cause), 0);
    check("rst_cycle",  32'(cycle_cnt), 0);
    check("rst_instret", 32'(instret_cnt), 0);

    // Free run, 10 retiring cycles.
    pulse_run();
    check("run_en", 32'(cpu_en), 1);
    retire = 1'b1;
    repeat (10) tick();
    retire = 1'b0;
    check("run10_cycle",   32'(cycle_cnt), 10);
    check("run10_instret", 32'(instret_cnt), 10);

    // Step 3 with retire every other cycle.
    cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
    check("halt_cmd_cause", 32'(halt_cause), 1);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    step_n = 8'd3; cmd_step = 1'b1; tick(); cmd_step = 1'b0;
    for (int k = 0; k < 8; k++) begin
      retire = (k % 2 == 0);
      tick();
    end
    retire = 1'b0;
    check("step3_halted",  32'(halted), 1);
    check("step3_cause",   32'(halt_cause), 2);
    check("step3_cycle",   32'(cycle_cnt), 5);
    check("step3_instret", 32'(instret_cnt), 3);
    step_n = 8'd0; cmd_step = 1'b1; tick(); cmd_step = 1'b0;
    tick();
    check("step0_halted", 32'(halted), 1);

    // Breakpoint at 0x10 in slot 2.
    bp_write(2, 32'h10, 1'b1);
    pc = 32'h0;
    pulse_run();
    retire = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pc = 32'(4 * k);
      tick();
    end
    pc = 32'h10;
    #1 check("bp_freeze_en", 32'(cpu_en), 0);
    tick();
    check("bp_cause", 32'(halt_cause), 3);
    check("bp_hit_idx", 32'(hit_idx), 2);
    retire = 1'b0;
    pulse_run();
    retire = 1'b1;
    #1 check("bp_resume_en", 32'(cpu_en), 1);
    tick();
    for (int k = 5; k < 8; k++) begin
      pc = 32'(4 * k);
      tick();
    end
    pc = 32'h10;
    tick();
    check("bp_rehit_halted", 32'(halted), 1);
    check("bp_rehit_cause", 32'(halt_cause), 3);
    retire = 1'b0;

    // Two slots on 0x20, plus writes to nonexistent slots 6 and 7.
    bp_write(1, 32'h20, 1'b1);
    bp_write(3, 32'h20, 1'b1);
    bp_write(6, 32'h30, 1'b1);
    bp_write(7, 32'h30, 1'b1);
    pulse_run();
    retire = 1'b1;
    tick();
    pc = 32'h30;
    #1 check("bad_idx_no_bp", 32'(cpu_en), 1);
    tick();
    pc = 32'h20;
    tick();
    check("multi_hit_idx", 32'(hit_idx), 1);
    retire = 1'b0;

    // stop together with cmd_halt, then stop alone, then resume onto stop.
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    pulse_run();
    retire = 1'b1;
    tick();
    pc = 32'h24; stop = 1'b1; cmd_halt = 1'b1;
    #1 check("stop_halt_en", 32'(cpu_en), 0);
    tick();
    stop = 1'b0; cmd_halt = 1'b0;
    check("stop_halt_cause", 32'(halt_cause), 1);
    pulse_run();
    tick();
    pc = 32'h28; stop = 1'b1;
    #1 check("stop_en", 32'(cpu_en), 0);
    tick();
    check("stop_cause", 32'(halt_cause), 4);
    check("stop_instret", 32'(instret_cnt), 2);
    pulse_run();
    tick();
    check("stop_rehalt", 32'(halted), 1);
    stop = 1'b0; retire = 1'b0;

    // Counter wrap at CNT_W=4 and clear-over-increment.
    pc = 32'h100;
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    pulse_run();
    retire = 1'b1;
    repeat (17) tick();
    check("wrap_cycle",   32'(cycle_cnt), 1);
    check("wrap_instret", 32'(instret_cnt), 1);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("clr_cycle",   32'(cycle_cnt), 0);
    check("clr_instret", 32'(instret_cnt), 0);
    retire = 1'b0;

    // Reset in the middle of a step.
    cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
    step_n = 8'd10; cmd_step = 1'b1; tick(); cmd_step = 1'b0;
    retire = 1'b1;
    repeat (2) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_halted", 32'(halted), 1);
    check("mid_rst_cause",  32'(halt_cause), 0);
    check("mid_rst_en",     32'(cpu_en), 0);
    pulse_run();
    pc = 32'h4; tick();
    pc = 32'h10;
    #1 check("rst_clears_bp", 32'(cpu_en), 1);
    tick();
    idle();

    // Randomized phase against the model.
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      cmd_run  = ($urandom_range(0, 7) == 0);
      cmd_step = ($urandom_range(0, 9) == 0);
      cmd_halt = ($urandom_range(0, 11) == 0);
      step_n   = STEP_W'($urandom_range(0, 4));
      bp_we    = ($urandom_range(0, 7) == 0);
      bp_idx   = BPI_W'($urandom_range(0, 7));
      bp_addr  = 32'($urandom_range(0, 7) * 16);
      bp_en_in = ($urandom_range(0, 3) != 0);
      pc       = 32'($urandom_range(0, 7) * 16);
      retire   = $urandom_range(0, 1) == 1;
      stop     = ($urandom_range(0, 15) == 0);
      cnt_clr  = ($urandom_range(0, 31) == 0);
      tick();
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
